uart_fifo_bridge: RTL and testbench
===================================

UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

Interface
REQ-001 Parameter: DEPTH, 8, entries per FIFO; power of 2, at least 2.
REQ-002 Parameter: WIDTH, 8, bits per entry.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port: CLK  in  1  rising-edge clock.
REQ-005 Port: reset_n  in  1  asynchronous active-low reset.
REQ-006 Port: DataIn  in  WIDTH  CPU transmit byte.
REQ-007 Port: DataInValid  in  1  CPU transmit push strobe.
REQ-008 Port: DataInReady  out  1  TX FIFO not full.
REQ-009 Port: DataOut  out  WIDTH  RX FIFO head, first-word-fall-through.
REQ-010 Port: DataOutValid  out  1  RX FIFO not empty.
REQ-011 Port: DataOutReady  in  1  CPU receive pop strobe.
REQ-012 Port: tx_data  out  WIDTH  TX FIFO head, to the serializer.
REQ-013 Port: tx_valid  out  1  TX FIFO not empty.
REQ-014 Port: tx_ready  in  1  serializer accepts tx_data.
REQ-015 Port: rx_data  in  WIDTH  byte from the deserializer.
REQ-016 Port: rx_valid  in  1  deserializer byte strobe.
REQ-017 Port: rx_ready  out  1  RX FIFO accepts a byte.
REQ-018 Port: tx_count, rx_count  out  log2(DEPTH)+1  occupancy of each FIFO.
REQ-019 Port: rx_overflow  out  1  sticky flag: an RX byte was dropped.
REQ-020 Port: ovf_clear  in  1  clears rx_overflow.

Function
REQ-021 There SHALL be two independent circular FIFOs (TX and RX), each with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-022 Each FIFO SHALL have a registered occupancy count of log2(DEPTH)+1 bits.
REQ-023 The full flag SHALL be count==DEPTH; the empty flag SHALL be count==0. Both SHALL derive from registered state only.
REQ-024 TX push: DataInValid && DataInReady writes DataIn at the write pointer.
  - The byte appears on tx_data/tx_valid the next cycle (1-cycle latency).
  - DataInValid while the FIFO is full is ignored: no state change, data lost.
REQ-025 TX pop: tx_valid && tx_ready advances the read pointer.
  - tx_data SHALL be stable while tx_valid=1 and tx_ready=0.
REQ-026 RX push: rx_valid && rx_ready writes rx_data.
  - DataOut/DataOutValid reflect the byte the next cycle.
REQ-027 RX pop: DataOutValid && DataOutReady advances the read pointer; DataOutReady while empty is ignored.
REQ-028 Simultaneous push and pop on a non-empty, non-full FIFO: both take effect and the count is unchanged.
REQ-029 Simultaneous push and pop on an empty FIFO: only the push takes effect and the count becomes 1.
REQ-030 Simultaneous push and pop on a full FIFO: only the pop takes effect and the count becomes DEPTH-1.
  - A push is never accepted into the slot freed in the same cycle.
REQ-031 All outputs SHALL be functions of registers only; there are no combinational paths from inputs to outputs.
  - Exception: rx_ready, when UART_FIFO_OVERFLOW_EN is undefined, is derived from the registered full flag.

Reset
REQ-032 While reset_n=0 the following outputs SHALL be held at these values:
  - 0: pointers, counts, tx_valid, DataOutValid, rx_overflow.
  - 1: DataInReady and rx_ready.
REQ-033 Assertion of reset_n mid-transfer SHALL discard all FIFO contents immediately.
  - Data outputs are don't-care while the corresponding valid is 0.
REQ-034 Deassertion of reset_n SHALL be synchronised internally, so that the first push is accepted on the second rising CLK edge after deassertion.

Configuration
REQ-035 Macro: UART_FIFO_OVERFLOW_EN.
REQ-036 When UART_FIFO_OVERFLOW_EN is defined:
  - rx_ready is tied to 1.
  - rx_valid while the RX FIFO is full drops the byte and sets rx_overflow the next cycle.
  - ovf_clear=1 clears rx_overflow.
  - If a drop and ovf_clear occur in the same cycle, the set wins.
REQ-037 When UART_FIFO_OVERFLOW_EN is undefined:
  - rx_ready = !RX full.
  - rx_overflow is tied to 0.
  - ovf_clear is ignored.

Verification
REQ-038 Scenario 1, TX latency: after reset, push 0x41 -> next cycle tx_valid=1, tx_data=0x41, tx_count=1; with tx_ready=1 the following cycle, tx_count becomes 0.
REQ-039 Scenario 2, TX ordering and full: with tx_ready=0, push 0x00..0x08 -> the first 8 bytes are accepted, DataInReady=0, and 0x08 is lost; drain with tx_ready=1 -> 0x00..0x07 appear in order.
REQ-040 Scenario 3, simultaneous push/pop on full (DEPTH=8): both strobes asserted at count=8 -> count becomes 7 and the pushed byte is absent from the drained sequence.
REQ-041 Scenario 4, RX overflow with macro defined: 9 rx_valid bytes with no pops -> rx_overflow=1, rx_count=8, DataOut=first byte; pulse ovf_clear -> rx_overflow=0.
REQ-042 Scenario 5, RX backpressure with macro undefined: 8 bytes in -> rx_ready=0; one pop -> rx_ready=1 the next cycle.
REQ-043 Scenario 6, reset mid-operation: with tx_count=5, pulse reset_n low for 1 ns between edges -> tx_valid=0 and tx_count=0 immediately; no stale byte appears after release.

Source files
------------

// File: rtl/uart_fifo_bridge.sv
`timescale 1ns/1ps
// uart_fifo_bridge: CPU <-> UART byte buffering, one first-word-fall-through FIFO per direction.
// Latency: a byte pushed on one edge is visible at the FIFO head after that edge (1 cycle).
// Backpressure: DataInReady/rx_ready low when full; with UART_FIFO_OVERFLOW_EN, rx_ready=1 and overflowing RX bytes are dropped and flagged.

// Generic circular FIFO with registered occupancy count and first-word-fall-through read port.
module uart_fifo_bridge_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Flags come straight from the registered count, so they never see this cycle's strobes.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even if a pop frees a slot in the same cycle;
  // an empty FIFO ignores the pop even if a push lands in the same cycle.
  assign push = wr_i && !full_o;
  assign pop  = rd_i && !empty_o;

  // Next-state pointers and count; pointers wrap naturally because DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while the FIFO is empty, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// Top level: TX path (CPU -> serializer) and RX path (deserializer -> CPU).
module uart_fifo_bridge #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       DataIn,
  input  logic                   DataInValid,
  output logic                   DataInReady,
  output logic [WIDTH-1:0]       DataOut,
  output logic                   DataOutValid,
  input  logic                   DataOutReady,
  output logic [WIDTH-1:0]       tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   rx_overflow,
  input  logic                   ovf_clear
);

  logic rst_sync_q;
  logic tx_full, tx_empty;
  logic rx_full, rx_empty;

  // Reset release synchroniser: assertion is immediate, release takes effect one edge later,
  // so the first push after reset_n rises is taken on the second rising edge.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= 1'b0;
    end else begin
      rst_sync_q <= 1'b1;
    end
  end

  uart_fifo_bridge_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_tx_fifo (
    .clk_i   (CLK),
    .rst_ni  (rst_sync_q),
    .wr_i    (DataInValid),
    .wdata_i (DataIn),
    .rd_i    (tx_ready),
    .rdata_o (tx_data),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  assign DataInReady = !tx_full;
  assign tx_valid    = !tx_empty;

  uart_fifo_bridge_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_rx_fifo (
    .clk_i   (CLK),
    .rst_ni  (rst_sync_q),
    .wr_i    (rx_valid),
    .wdata_i (rx_data),
    .rd_i    (DataOutReady),
    .rdata_o (DataOut),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign DataOutValid = !rx_empty;

`ifdef UART_FIFO_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic rx_drop;

  // The deserializer cannot be stalled: bytes arriving at a full RX FIFO are dropped.
  assign rx_ready    = 1'b1;
  assign rx_drop     = rx_valid && rx_full;
  assign rx_overflow = ovf_q;

  // Sticky overflow flag; a drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clear) begin
      ovf_d = 1'b0;
    end
    if (rx_drop) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge CLK or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`else
  logic ovf_clear_unused;

  // Deserializer is held off by the registered full flag; no byte is ever dropped.
  assign rx_ready         = !rx_full;
  assign rx_overflow      = 1'b0;
  assign ovf_clear_unused = ovf_clear;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
`timescale 1ns/1ps
// tb_uart_fifo_bridge: directed scenarios with a queue-based reference model.
// Latency: model updates on each rising edge; outputs compared on every falling edge.
// Backpressure: model refuses pushes when its queue holds DEPTH bytes.
module tb_uart_fifo_bridge;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] DataIn;
  logic             DataInValid;
  logic             DataInReady;
  logic [WIDTH-1:0] DataOut;
  logic             DataOutValid;
  logic             DataOutReady;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [3:0]       tx_count;
  logic [3:0]       rx_count;
  logic             rx_overflow;
  logic             ovf_clear;

  uart_fifo_bridge #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .DataIn       (DataIn),
    .DataInValid  (DataInValid),
    .DataInReady  (DataInReady),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .rx_overflow  (rx_overflow),
    .ovf_clear    (ovf_clear)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference model: byte queues plus a sticky flag; release counts edges after reset_n rises.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] seen[$];
  bit         mdl_ovf;
  int         edges_since_release;
  int         tn, rn;

  always @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      txq.delete();
      rxq.delete();
      mdl_ovf = 1'b0;
      edges_since_release = 0;
    end else if (edges_since_release == 0) begin
      edges_since_release = 1;
    end else begin
      tn = txq.size();
      rn = rxq.size();
      if (tx_ready && tn > 0) void'(txq.pop_front());
      if (DataInValid && tn < DEPTH) txq.push_back(DataIn);
      if (DataOutReady && rn > 0) void'(rxq.pop_front());
      if (rx_valid && rn < DEPTH) rxq.push_back(rx_data);
`ifdef UART_FIFO_OVERFLOW_EN
      if (rx_valid && rn == DEPTH) mdl_ovf = 1'b1;
      else if (ovf_clear) mdl_ovf = 1'b0;
`endif
    end
  end

  // Every-cycle comparison of all outputs against the model, away from the rising edge.
  always @(negedge CLK) begin
    chk("tx_count", tx_count, txq.size());
    chk("tx_valid", tx_valid, txq.size() != 0);
    chk("DataInReady", DataInReady, txq.size() < DEPTH);
    if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
    chk("rx_count", rx_count, rxq.size());
    chk("DataOutValid", DataOutValid, rxq.size() != 0);
    if (rxq.size() != 0) chk("DataOut", DataOut, rxq[0]);
`ifdef UART_FIFO_OVERFLOW_EN
    chk("rx_ready", rx_ready, 1);
`else
    chk("rx_ready", rx_ready, rxq.size() < DEPTH);
`endif
    chk("rx_overflow", rx_overflow, mdl_ovf);
    if (reset_n && tx_valid && tx_ready) seen.push_back(tx_data);
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; DataIn = '0; DataInValid = 1'b0; DataOutReady = 1'b0;
    tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0; ovf_clear = 1'b0;
    repeat (3) cyc();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_DataInReady", DataInReady, 1);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_DataOutValid", DataOutValid, 0);
    chk("rst_rx_overflow", rx_overflow, 0);

    // Release: a push on the first edge is lost, the push on the second edge lands.
    reset_n = 1'b1; DataInValid = 1'b1; DataIn = 8'hEE;
    cyc();
    DataIn = 8'h41;
    cyc();
    DataInValid = 1'b0;
    chk("s1_tx_valid", tx_valid, 1);
    chk("s1_tx_data", tx_data, 8'h41);
    chk("s1_tx_count", tx_count, 1);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    chk("s1_drain_count", tx_count, 0);

    // Ordering and full: 9 pushes with no pops, 0x08 is lost.
    for (int i = 0; i < 9; i++) begin
      DataInValid = 1'b1; DataIn = 8'(i);
      cyc();
    end
    DataInValid = 1'b0;
    chk("s2_full_count", tx_count, 8);
    chk("s2_full_ready", DataInReady, 0);
    chk("s2_head", tx_data, 8'h00);
    seen.delete();
    tx_ready = 1'b1;
    repeat (10) cyc();
    tx_ready = 1'b0;
    chk("s2_drain_len", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk("s2_order", seen[i], 32'(i));

    // Simultaneous push/pop on full: only the pop happens.
    for (int i = 0; i < 8; i++) begin
      DataInValid = 1'b1; DataIn = 8'(8'h10 + i);
      cyc();
    end
    seen.delete();
    DataIn = 8'hAA; tx_ready = 1'b1;
    cyc();
    DataInValid = 1'b0;
    chk("s3_count", tx_count, 7);
    chk("s3_ready", DataInReady, 1);
    repeat (9) cyc();
    tx_ready = 1'b0;
    chk("s3_drain_len", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) chk("s3_order", seen[i], 32'(8'h10 + i));

    // Simultaneous push/pop on empty, then in the middle of the range.
    DataInValid = 1'b1; DataIn = 8'h5A; tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    chk("empty_pp_count", tx_count, 1);
    chk("empty_pp_data", tx_data, 8'h5A);
    DataIn = 8'h5B; cyc();
    DataIn = 8'h5C; cyc();
    DataIn = 8'h5D; tx_ready = 1'b1;
    cyc();
    DataInValid = 1'b0;
    chk("mid_pp_count", tx_count, 3);
    chk("mid_pp_head", tx_data, 8'h5B);
    repeat (4) cyc();
    tx_ready = 1'b0;

`ifdef UART_FIFO_OVERFLOW_EN
    // RX overflow: the 9th byte is dropped and flagged; a same-cycle drop beats the clear.
    for (int i = 0; i < 9; i++) begin
      rx_valid = 1'b1; rx_data = 8'(8'h60 + i);
      cyc();
    end
    rx_valid = 1'b0;
    chk("s4_ovf", rx_overflow, 1);
    chk("s4_count", rx_count, 8);
    chk("s4_head", DataOut, 8'h60);
    ovf_clear = 1'b1; cyc(); ovf_clear = 1'b0;
    chk("s4_clear", rx_overflow, 0);
    ovf_clear = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
    cyc();
    ovf_clear = 1'b0; rx_valid = 1'b0;
    chk("s4_set_wins", rx_overflow, 1);
    ovf_clear = 1'b1; cyc(); ovf_clear = 1'b0;
`else
    // RX backpressure: rx_ready drops at 8 bytes and returns the cycle after one pop.
    for (int i = 0; i < 9; i++) begin
      rx_valid = 1'b1; rx_data = 8'(8'h60 + i);
      cyc();
    end
    rx_valid = 1'b0;
    chk("s5_ready_full", rx_ready, 0);
    chk("s5_count", rx_count, 8);
    chk("s5_head", DataOut, 8'h60);
    DataOutReady = 1'b1; cyc(); DataOutReady = 1'b0;
    chk("s5_ready_back", rx_ready, 1);
    chk("s5_count_pop", rx_count, 7);
    chk("s5_next_head", DataOut, 8'h61);
    ovf_clear = 1'b1; cyc(); ovf_clear = 1'b0;
    chk("s5_no_ovf", rx_overflow, 0);
`endif
    DataOutReady = 1'b1;
    repeat (9) cyc();
    DataOutReady = 1'b0;
    chk("rx_drained", DataOutValid, 0);

    // Reset mid-operation: contents vanish at once and nothing stale reappears.
    for (int i = 0; i < 5; i++) begin
      DataInValid = 1'b1; DataIn = 8'(8'h30 + i);
      cyc();
    end
    DataInValid = 1'b0;
    chk("s6_count_before", tx_count, 5);
    reset_n = 1'b0;
    #1;
    chk("s6_valid_now", tx_valid, 0);
    chk("s6_count_now", tx_count, 0);
    chk("s6_ready_now", DataInReady, 1);
    reset_n = 1'b1;
    seen.delete();
    tx_ready = 1'b1;
    repeat (5) cyc();
    tx_ready = 1'b0;
    chk("s6_no_stale", seen.size(), 0);
    chk("s6_valid_after", tx_valid, 0);
    chk("s6_count_after", tx_count, 0);

    repeat (2) cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
